// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: program counter, next-PC select and IF/ID pipeline register.
module instruction_fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic        uncond_br,
   input  logic        br_reg,
   input  logic [63:0] br_reg_data,
   output logic [63:0] instr_addr,
   input  logic [31:0] instr_data,
   output logic [31:0] id_instr,
   output logic [63:0] id_pc,
   output logic [63:0] id_noBrPC,
   output logic        id_valid
);

   logic [63:0] pc_q, pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [63:0] id_pc_q, id_pc_d;
   logic [63:0] id_nobrpc_q, id_nobrpc_d;
   logic        id_valid_q, id_valid_d;

   logic [63:0] pc_plus4;
   logic [63:0] imm26_off;
   logic [63:0] imm19_off;
   logic [63:0] br_target;
   logic        redirect;

   // Word offsets are sign-extended and scaled by 4 before adding to the branch's own PC.
   always_comb begin
      pc_plus4  = pc_q + 64'd4;
      imm26_off = {{36{id_instr_q[25]}}, id_instr_q[25:0], 2'b00};
      imm19_off = {{43{id_instr_q[23]}}, id_instr_q[23:5], 2'b00};
      if (br_reg) begin
         br_target = br_reg_data;
      end else if (uncond_br) begin
         br_target = id_pc_q + imm26_off;
      end else begin
         br_target = id_pc_q + imm19_off;
      end
      redirect = br_taken & id_valid_q & ~stall;
   end

   always_comb begin
      pc_d        = pc_q;
      id_instr_d  = id_instr_q;
      id_pc_d     = id_pc_q;
      id_nobrpc_d = id_nobrpc_q;
      id_valid_d  = id_valid_q;
      if (stall) begin
         pc_d = pc_q;
      end else if (redirect) begin
         // The instruction fetched this cycle is on the wrong path; replace it with a bubble.
         pc_d        = br_target;
         id_instr_d  = NOP_INSTR;
         id_pc_d     = 64'd0;
         id_nobrpc_d = 64'd0;
         id_valid_d  = 1'b0;
      end else begin
         pc_d        = pc_plus4;
         id_instr_d  = instr_data;
         id_pc_d     = pc_q;
         id_nobrpc_d = pc_plus4;
         id_valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         id_instr_q  <= NOP_INSTR;
         id_pc_q     <= 64'd0;
         id_nobrpc_q <= 64'd0;
         id_valid_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         id_instr_q  <= id_instr_d;
         id_pc_q     <= id_pc_d;
         id_nobrpc_q <= id_nobrpc_d;
         id_valid_q  <= id_valid_d;
      end
   end

   assign instr_addr = pc_q;
   assign id_instr   = id_instr_q;
   assign id_pc      = id_pc_q;
   assign id_noBrPC  = id_nobrpc_q;
   assign id_valid   = id_valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed bench for instruction_fetch_stage.
module tb_instruction_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic        uncond_br = 1'b0;
   logic        br_reg = 1'b0;
   logic [63:0] br_reg_data = 64'd0;
   logic        mem_x = 1'b0;
   logic [63:0] instr_addr;
   logic [31:0] instr_data;
   logic [31:0] id_instr;
   logic [63:0] id_pc;
   logic [63:0] id_noBrPC;
   logic        id_valid;

   logic        w_reset = 1'b1;
   logic        w_br_taken = 1'b1;
   logic [63:0] w_addr;
   logic [31:0] w_data;
   logic [31:0] w_instr;
   logic [63:0] w_pc;
   logic [63:0] w_nobr;
   logic        w_valid;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Program image: CBZ imm19=-2 at 0x8, B imm26=3 at 0x10, tagged filler elsewhere.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] w;
      case (a)
         64'h8:   begin w = 32'hB400_0000; w[23:5] = 19'h7FFFE; end
         64'h10:  begin w = 32'h1400_0000; w[25:0] = 26'd3; end
         default: w = {16'hCAFE, a[15:0]};
      endcase
      return w;
   endfunction

   assign instr_data = mem_x ? 32'hxxxx_xxxx : mem_word(instr_addr);
   assign w_data     = mem_word(w_addr);

   instruction_fetch_stage #(.RESET_PC(64'h0), .NOP_INSTR(32'h0)) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
      .uncond_br(uncond_br), .br_reg(br_reg), .br_reg_data(br_reg_data),
      .instr_addr(instr_addr), .instr_data(instr_data), .id_instr(id_instr),
      .id_pc(id_pc), .id_noBrPC(id_noBrPC), .id_valid(id_valid)
   );

   instruction_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .NOP_INSTR(32'h0)) u_wrap (
      .clk(clk), .reset(w_reset), .stall(1'b0), .br_taken(w_br_taken),
      .uncond_br(1'b0), .br_reg(1'b0), .br_reg_data(64'd0),
      .instr_addr(w_addr), .instr_data(w_data), .id_instr(w_instr),
      .id_pc(w_pc), .id_noBrPC(w_nobr), .id_valid(w_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++; if (instr_addr !== 64'h0) begin bad++; $display("FAIL rst_pc got %h want %h", instr_addr, 64'h0); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", id_valid); end
      total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got %h want 0", id_instr); end
      total++; if (id_pc !== 64'h0) begin bad++; $display("FAIL rst_id_pc got %h want 0", id_pc); end
      total++; if (id_noBrPC !== 64'h0) begin bad++; $display("FAIL rst_nobr got %h want 0", id_noBrPC); end
   endtask

   task automatic test_sequential();
      reset = 1'b0;
      tick();
      total++; if (id_pc !== 64'h0) begin bad++; $display("FAIL seq1_id_pc got %h want 0", id_pc); end
      total++; if (id_noBrPC !== 64'h4) begin bad++; $display("FAIL seq1_nobr got %h want 4", id_noBrPC); end
      total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL seq1_valid got %b want 1", id_valid); end
      total++; if (id_instr !== 32'hCAFE_0000) begin bad++; $display("FAIL seq1_instr got %h want CAFE0000", id_instr); end
      total++; if (instr_addr !== 64'h4) begin bad++; $display("FAIL seq1_addr got %h want 4", instr_addr); end
      tick();
      total++; if (id_pc !== 64'h4) begin bad++; $display("FAIL seq2_id_pc got %h want 4", id_pc); end
      total++; if (instr_addr !== 64'h8) begin bad++; $display("FAIL seq2_addr got %h want 8", instr_addr); end
   endtask

   task automatic test_cond_branch();
      tick();
      total++; if (id_pc !== 64'h8) begin bad++; $display("FAIL cbz_id_pc got %h want 8", id_pc); end
      total++; if (id_instr !== 32'hB4FF_FFC0) begin bad++; $display("FAIL cbz_instr got %h want B4FFFFC0", id_instr); end
      total++; if (instr_addr !== 64'hC) begin bad++; $display("FAIL cbz_addr got %h want C", instr_addr); end
      br_taken = 1'b1;
      uncond_br = 1'b0;
      tick();
      br_taken = 1'b0;
      total++; if (instr_addr !== 64'h0) begin bad++; $display("FAIL cbz_target got %h want 0", instr_addr); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL cbz_bubble got %b want 0", id_valid); end
      total++; if (id_pc !== 64'h0) begin bad++; $display("FAIL cbz_bubble_pc got %h want 0", id_pc); end
      tick();
      total++; if (id_pc !== 64'h0 || id_valid !== 1'b1) begin bad++; $display("FAIL cbz_refetch got pc=%h v=%b want pc=0 v=1", id_pc, id_valid); end
      total++; if (instr_addr !== 64'h4) begin bad++; $display("FAIL cbz_refetch_addr got %h want 4", instr_addr); end
   endtask

   task automatic test_uncond_branch();
      repeat (4) tick();
      total++; if (id_pc !== 64'h10) begin bad++; $display("FAIL b_id_pc got %h want 10", id_pc); end
      total++; if (id_instr !== 32'h1400_0003) begin bad++; $display("FAIL b_instr got %h want 14000003", id_instr); end
      br_taken = 1'b1;
      uncond_br = 1'b1;
      tick();
      br_taken = 1'b0;
      uncond_br = 1'b0;
      total++; if (instr_addr !== 64'h1C) begin bad++; $display("FAIL b_target got %h want 1C", instr_addr); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL b_bubble got %b want 0", id_valid); end
      tick();
      total++; if (id_pc !== 64'h1C) begin bad++; $display("FAIL b_land got %h want 1C", id_pc); end
      tick();
      total++; if (id_pc !== 64'h20 || instr_addr !== 64'h24) begin bad++; $display("FAIL b_next got pc=%h addr=%h want 20/24", id_pc, instr_addr); end
   endtask

   task automatic test_stall_branch();
      stall = 1'b1;
      br_taken = 1'b1;
      br_reg = 1'b1;
      br_reg_data = 64'h30;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (instr_addr !== 64'h24) begin bad++; $display("FAIL stall%0d_addr got %h want 24", i, instr_addr); end
         total++; if (id_pc !== 64'h20 || id_valid !== 1'b1) begin bad++; $display("FAIL stall%0d_ifid got pc=%h v=%b want 20/1", i, id_pc, id_valid); end
      end
      stall = 1'b0;
      tick();
      br_taken = 1'b0;
      br_reg = 1'b0;
      total++; if (instr_addr !== 64'h30) begin bad++; $display("FAIL unstall_redirect got %h want 30", instr_addr); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL unstall_bubble got %b want 0", id_valid); end
   endtask

   task automatic test_reset_mid_stall();
      stall = 1'b1;
      mem_x = 1'b1;
      tick();
      total++; if (instr_addr !== 64'h30) begin bad++; $display("FAIL rms_hold got %h want 30", instr_addr); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (instr_addr !== 64'h0) begin bad++; $display("FAIL rms_pc got %h want 0", instr_addr); end
      total++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin bad++; $display("FAIL rms_ifid got v=%b i=%h want 0/0", id_valid, id_instr); end
      tick();
      total++; if (instr_addr !== 64'h0 || id_instr !== 32'h0) begin bad++; $display("FAIL rms_stall_x got addr=%h i=%h want 0/0", instr_addr, id_instr); end
      stall = 1'b0;
      mem_x = 1'b0;
      tick();
      total++; if (id_pc !== 64'h0 || id_valid !== 1'b1 || id_instr !== 32'hCAFE_0000) begin bad++; $display("FAIL rms_first got pc=%h v=%b i=%h want 0/1/CAFE0000", id_pc, id_valid, id_instr); end
      total++; if (instr_addr !== 64'h4) begin bad++; $display("FAIL rms_addr got %h want 4", instr_addr); end
   endtask

   task automatic test_br_reg();
      repeat (4) tick();
      total++; if (id_pc !== 64'h10 || id_noBrPC !== 64'h14) begin bad++; $display("FAIL br_pre got pc=%h nobr=%h want 10/14", id_pc, id_noBrPC); end
      br_taken = 1'b1;
      br_reg = 1'b1;
      uncond_br = 1'b1;
      br_reg_data = 64'h40;
      tick();
      br_taken = 1'b0;
      br_reg = 1'b0;
      uncond_br = 1'b0;
      br_reg_data = 64'hxxxx_xxxx_xxxx_xxxx;
      total++; if (instr_addr !== 64'h40) begin bad++; $display("FAIL br_target got %h want 40", instr_addr); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL br_bubble got %b want 0", id_valid); end
      tick();
      total++; if (id_pc !== 64'h40 || id_noBrPC !== 64'h44 || id_valid !== 1'b1) begin bad++; $display("FAIL br_land got pc=%h nobr=%h v=%b want 40/44/1", id_pc, id_noBrPC, id_valid); end
      total++; if (instr_addr !== 64'h44) begin bad++; $display("FAIL br_addr got %h want 44", instr_addr); end
   endtask

   task automatic test_wrap();
      total++; if (w_addr !== 64'hFFFF_FFFF_FFFF_FFFC || w_valid !== 1'b0) begin bad++; $display("FAIL wrap_rst got addr=%h v=%b want FFFFFFFFFFFFFFFC/0", w_addr, w_valid); end
      w_reset = 1'b0;
      tick();
      total++; if (w_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_id_pc got %h want FFFFFFFFFFFFFFFC", w_pc); end
      total++; if (w_nobr !== 64'h0) begin bad++; $display("FAIL wrap_nobr got %h want 0", w_nobr); end
      total++; if (w_addr !== 64'h0 || w_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc got addr=%h v=%b want 0/1", w_addr, w_valid); end
      total++; if (w_instr !== 32'hCAFE_FFFC) begin bad++; $display("FAIL wrap_instr got %h want CAFEFFFC", w_instr); end
      w_br_taken = 1'b0;
      tick();
      total++; if (w_pc !== 64'h0 || w_addr !== 64'h4) begin bad++; $display("FAIL wrap_next got pc=%h addr=%h want 0/4", w_pc, w_addr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_cond_branch();
      test_uncond_branch();
      test_stall_branch();
      test_reset_mid_stall();
      test_br_reg();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
